// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - ID-side operand/issue/return bundle between pipeline (master) and scoreboard (slave)
interface fwd_scoreboard_if #(
    parameter int REG_AW   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_STG  = 2,
    parameter int MAX_PEND = 4
);
    localparam int SELW = $clog2(NUM_STG + 2);
    localparam int CW   = $clog2(MAX_PEND + 1);

    logic [NUM_RD-1:0]         rd_en;
    logic [NUM_RD*REG_AW-1:0]  rd_addr;
    logic [NUM_STG-1:0]        stg_we;
    logic [NUM_STG*REG_AW-1:0] stg_rd;
    logic                      iss_valid;
    logic                      iss_we;
    logic                      iss_is_load;
    logic [REG_AW-1:0]         iss_rd;
    logic                      ld_ret_valid;
    logic [REG_AW-1:0]         ld_ret_rd;
    logic [NUM_RD*SELW-1:0]    fwd_sel;
    logic                      stall;
    logic                      iss_accept;
    logic [CW-1:0]             pend_cnt;
    logic                      sb_err;

    modport master (
        output rd_en, rd_addr, stg_we, stg_rd,
        output iss_valid, iss_we, iss_is_load, iss_rd,
        output ld_ret_valid, ld_ret_rd,
        input  fwd_sel, stall, iss_accept, pend_cnt, sb_err
    );

    modport slave (
        input  rd_en, rd_addr, stg_we, stg_rd,
        input  iss_valid, iss_we, iss_is_load, iss_rd,
        input  ld_ret_valid, ld_ret_rd,
        output fwd_sel, stall, iss_accept, pend_cnt, sb_err
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - operand bypass select, pending-load scoreboard and RAW/WAW/limit stall
// Optional FWD_PERF_EN adds saturating stall_cycles / stall_loads counters.
module fwd_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_STG  = 2,
    parameter int ZR_IDX   = 31,
    parameter int MAX_PEND = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FWD_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] stall_loads,
`endif
    fwd_scoreboard_if.slave bus
);
    localparam int SELW = $clog2(NUM_STG + 2);
    localparam int CW   = $clog2(MAX_PEND + 1);
    localparam int NREG = 1 << REG_AW;
    localparam logic [REG_AW-1:0] ZR       = REG_AW'(ZR_IDX);
    localparam logic [SELW-1:0]   SEL_RET  = SELW'(NUM_STG + 1);
    localparam logic [CW-1:0]     CNT_MAX  = CW'(MAX_PEND);

    logic [NREG-1:0] pend;
    logic [CW-1:0]   cnt_q;
    logic            err_q;

    logic [SELW-1:0] sel_arr [NUM_RD];
    logic            raw_hit [NUM_RD];
    logic            raw_stall;
    logic            waw_stall;
    logic            limit_stall;
    logic            stall_c;
    logic            accept_c;
    logic            set_c;
    logic            clr_c;
    logic            iss_ret_same;
    logic [CW-1:0]   cnt_n;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [REG_AW-1:0] addr;
        logic              live;
        logic              ret_hit;

        assign addr    = bus.rd_addr[p*REG_AW +: REG_AW];
        assign live    = bus.rd_en[p] && (addr != ZR);
        assign ret_hit = bus.ld_ret_valid && (bus.ld_ret_rd == addr);

        // Walk stages oldest to youngest so the youngest matching writer overrides.
        always_comb begin
            sel_arr[p] = '0;
            if (live) begin
                if (pend[addr] && ret_hit)
                    sel_arr[p] = SEL_RET;
                for (int s = NUM_STG - 1; s >= 0; s--) begin
                    if (bus.stg_we[s] && (bus.stg_rd[s*REG_AW +: REG_AW] == addr))
                        sel_arr[p] = SELW'(s + 1);
                end
            end
        end

        assign raw_hit[p] = live && pend[addr] && !ret_hit;
    end

    always_comb begin
        bus.fwd_sel = '0;
        raw_stall   = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            bus.fwd_sel[p*SELW +: SELW] = sel_arr[p];
            raw_stall = raw_stall | raw_hit[p];
        end
    end

    assign iss_ret_same = bus.ld_ret_valid && (bus.ld_ret_rd == bus.iss_rd);
    assign waw_stall    = bus.iss_valid && bus.iss_we && (bus.iss_rd != ZR)
                          && pend[bus.iss_rd] && !iss_ret_same;
    // A return in the same cycle frees a slot, so a full scoreboard may still take a load.
    assign limit_stall  = bus.iss_valid && bus.iss_is_load && (cnt_q == CNT_MAX)
                          && !bus.ld_ret_valid;
    assign stall_c      = raw_stall || waw_stall || limit_stall;
    assign accept_c     = bus.iss_valid && !stall_c;

    assign set_c = accept_c && bus.iss_is_load && bus.iss_we && (bus.iss_rd != ZR);
    assign clr_c = bus.ld_ret_valid && pend[bus.ld_ret_rd];

    // Clamped so a stray return in the same cycle as a full-scoreboard issue cannot overflow.
    always_comb begin
        cnt_n = cnt_q;
        if (set_c && !clr_c && (cnt_q != CNT_MAX))
            cnt_n = cnt_q + 1'b1;
        else if (clr_c && !set_c && (cnt_q != '0))
            cnt_n = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (clr_c)
                pend[bus.ld_ret_rd] <= 1'b0;
            if (set_c)
                pend[bus.iss_rd] <= 1'b1;
            cnt_q <= cnt_n;
            if (bus.ld_ret_valid && !pend[bus.ld_ret_rd])
                err_q <= 1'b1;
        end
    end

    assign bus.stall      = stall_c;
    assign bus.iss_accept = accept_c;
    assign bus.pend_cnt   = cnt_q;
    assign bus.sb_err     = err_q;

`ifdef FWD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            stall_loads  <= '0;
        end else begin
            if (stall_c && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (limit_stall && (stall_loads != 32'hFFFF_FFFF))
                stall_loads <= stall_loads + 32'd1;
        end
    end
`endif
endmodule
